// File: rtl/gpu_mcnt_ctrl_pkg.sv
// Shared definitions for the GPU master-counter controller: state codes,
// software command bit positions and status word layout.
package gpu_mcnt_pkg;

    typedef enum logic [1:0] {
        MS_IDLE     = 2'd0,
        MS_ARMED    = 2'd1,
        MS_RUN      = 2'd2,
        MS_STOPPING = 2'd3
    } mcnt_state_e;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ARMED    = 2'd1;
    localparam logic [1:0] ST_RUN      = 2'd2;
    localparam logic [1:0] ST_STOPPING = 2'd3;

    localparam int CMD_W    = 4;
    localparam int CMD_ARM  = 0;
    localparam int CMD_STOP = 1;
    localparam int CMD_SNAP = 2;
    localparam int CMD_CLR  = 3;

    localparam int STAT_STATE_LSB  = 0;
    localparam int STAT_STATE_W    = 2;
    localparam int STAT_WRAP_BIT   = 2;
    localparam int STAT_TXEN_BIT   = 3;
    localparam int STAT_CLRERR_BIT = 4;
    localparam int STAT_SEQ_LSB    = 8;
    localparam int STAT_SEQ_W      = 8;

    function automatic logic [31:0] pack_status(input logic [1:0] st,
                                                input logic       wrap,
                                                input logic       tx,
                                                input logic       clr_err,
                                                input logic [7:0] seq);
        logic [31:0] w;
        w = '0;
        w[STAT_STATE_LSB +: STAT_STATE_W] = st;
        w[STAT_WRAP_BIT]                  = wrap;
        w[STAT_TXEN_BIT]                  = tx;
        w[STAT_CLRERR_BIT]                = clr_err;
        w[STAT_SEQ_LSB +: STAT_SEQ_W]     = seq;
        return w;
    endfunction

endpackage

// File: rtl/gpu_mcnt_ctrl_if.sv
// Bus bundle between the F-engine fabric/software registers and the mcnt controller.
// tst_load/tst_mcnt preload the counter for test; tie low in the system.
interface gpu_mcnt_ctrl_if #(parameter int MCNT_W = 48);
    logic [31:0]       ctrl_in;
    logic              sync_in;
    logic              pkt_done;
    logic              tst_load;
    logic [MCNT_W-1:0] tst_mcnt;
    logic              tx_en;
    logic [MCNT_W-1:0] mcnt_o;
    logic [31:0]       mcnt_lsb_out;
    logic [31:0]       mcnt_msb_out;
    logic [31:0]       status_out;

    modport master (
        output ctrl_in, sync_in, pkt_done, tst_load, tst_mcnt,
        input  tx_en, mcnt_o, mcnt_lsb_out, mcnt_msb_out, status_out
    );

    modport slave (
        input  ctrl_in, sync_in, pkt_done, tst_load, tst_mcnt,
        output tx_en, mcnt_o, mcnt_lsb_out, mcnt_msb_out, status_out
    );
endinterface

// File: rtl/gpu_mcnt_ctrl_sw_cmd_edge.sv
// Two-register capture of a level-written software control field with rise detect.
// A bit only fires after it has been observed low since reset, so a level held across reset stays quiet.
module sw_cmd_edge #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] lvl_i,
    output logic [W-1:0] rise_o
);

    logic         loaded_q;
    logic [W-1:0] ctrl_s1_q;
    logic [W-1:0] ctrl_s2_q;
    logic [W-1:0] primed_q;

    // loaded_q marks that ctrl_s1_q holds a genuine sample rather than its reset value
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            loaded_q <= 1'b0;
        end else begin
            loaded_q <= 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_bit
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    ctrl_s1_q[gi] <= 1'b0;
                    ctrl_s2_q[gi] <= 1'b0;
                    primed_q[gi]  <= 1'b0;
                end else begin
                    ctrl_s1_q[gi] <= lvl_i[gi];
                    ctrl_s2_q[gi] <= ctrl_s1_q[gi];
                    primed_q[gi]  <= primed_q[gi] | (loaded_q & ~ctrl_s1_q[gi]);
                end
            end

            assign rise_o[gi] = ctrl_s1_q[gi] & ~ctrl_s2_q[gi] & primed_q[gi];
        end
    endgenerate

endmodule

// File: rtl/gpu_mcnt_ctrl.sv
// GPU-packet master counter sequencer: arm, start on sync, count packets, stop on sync,
// and publish coherent 64-bit snapshots plus a status word for the PPC registers.
module gpu_mcnt_ctrl
    import gpu_mcnt_pkg::*;
#(
    parameter int MCNT_W = 48
) (
    input  logic           user_clk,
    input  logic           user_rst_n,
    gpu_mcnt_ctrl_if.slave bus
);

    logic [CMD_W-1:0]  cmd_rise;
    logic [1:0]        state_q, state_d;
    logic              tx_en_q, tx_en_d;
    logic [MCNT_W-1:0] mcnt_q, mcnt_d;
    logic [31:0]       snap_lsb_q, snap_lsb_d;
    logic [31:0]       snap_msb_q, snap_msb_d;
    logic [7:0]        seq_q, seq_d;
    logic              wrap_q, wrap_d;
    logic              clr_err_q, clr_err_d;
    logic              auto_snap;
    logic              counting;
    logic [63:0]       mcnt_ext;
    logic              unused_ctrl_hi;

    assign unused_ctrl_hi = ^bus.ctrl_in[31:CMD_W];

    sw_cmd_edge #(.W(CMD_W)) u_cmd_edge (
        .clk_i  (user_clk),
        .rst_ni (user_rst_n),
        .lvl_i  (bus.ctrl_in[CMD_W-1:0]),
        .rise_o (cmd_rise)
    );

    assign mcnt_ext = 64'(mcnt_q);
    assign counting = (state_q == ST_RUN) || (state_q == ST_STOPPING);

    always_comb begin
        state_d    = state_q;
        tx_en_d    = tx_en_q;
        mcnt_d     = mcnt_q;
        snap_lsb_d = snap_lsb_q;
        snap_msb_d = snap_msb_q;
        seq_d      = seq_q;
        wrap_d     = wrap_q;
        clr_err_d  = clr_err_q;
        auto_snap  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // stop beats arm when both rise together
                if (cmd_rise[CMD_ARM] && !cmd_rise[CMD_STOP]) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (cmd_rise[CMD_STOP]) begin
                    state_d = ST_IDLE;
                end else if (bus.sync_in) begin
                    state_d = ST_RUN;
                    tx_en_d = 1'b1;
                    mcnt_d  = '0;
                end
            end
            ST_RUN: begin
                if (cmd_rise[CMD_STOP]) begin
                    state_d = ST_STOPPING;
                end
            end
            ST_STOPPING: begin
                if (bus.sync_in) begin
                    state_d   = ST_IDLE;
                    tx_en_d   = 1'b0;
                    auto_snap = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (counting && bus.pkt_done) begin
            mcnt_d = mcnt_q + MCNT_W'(1);
            if (&mcnt_q) begin
                wrap_d = 1'b1;
            end
        end

        if (bus.tst_load) begin
            mcnt_d = bus.tst_mcnt;
        end

        // snapshot always takes the pre-increment registered count
        if (cmd_rise[CMD_SNAP] || auto_snap) begin
            snap_lsb_d = mcnt_ext[31:0];
            snap_msb_d = mcnt_ext[63:32];
            seq_d      = seq_q + 8'd1;
        end

        if (cmd_rise[CMD_CLR]) begin
            if (state_q == ST_IDLE) begin
                mcnt_d     = '0;
                snap_lsb_d = '0;
                snap_msb_d = '0;
                seq_d      = '0;
                wrap_d     = 1'b0;
                clr_err_d  = 1'b0;
            end else begin
                clr_err_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state_q    <= ST_IDLE;
            tx_en_q    <= 1'b0;
            mcnt_q     <= '0;
            snap_lsb_q <= '0;
            snap_msb_q <= '0;
            seq_q      <= '0;
            wrap_q     <= 1'b0;
            clr_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_en_q    <= tx_en_d;
            mcnt_q     <= mcnt_d;
            snap_lsb_q <= snap_lsb_d;
            snap_msb_q <= snap_msb_d;
            seq_q      <= seq_d;
            wrap_q     <= wrap_d;
            clr_err_q  <= clr_err_d;
        end
    end

    assign bus.tx_en        = tx_en_q;
    assign bus.mcnt_o       = mcnt_q;
    assign bus.mcnt_lsb_out = snap_lsb_q;
    assign bus.mcnt_msb_out = snap_msb_q;
    assign bus.status_out   = pack_status(state_q, wrap_q, tx_en_q, clr_err_q, seq_q);

endmodule

// File: tb/tb_gpu_mcnt_ctrl.sv
// Directed bench for gpu_mcnt_ctrl: drives on the falling edge, checks on the next falling edge.
module tb_gpu_mcnt_ctrl;

    localparam int MCNT_W = 48;
    localparam logic [31:0] ARM  = 32'h1;
    localparam logic [31:0] STOP = 32'h2;
    localparam logic [31:0] SNAP = 32'h4;
    localparam logic [31:0] CLR  = 32'h8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_total = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    gpu_mcnt_ctrl_if #(.MCNT_W(MCNT_W)) ifc ();

    gpu_mcnt_ctrl #(.MCNT_W(MCNT_W)) dut (
        .user_clk   (clk),
        .user_rst_n (rst_n),
        .bus        (ifc.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cmd_on(input logic [31:0] c);
        ifc.ctrl_in = c;
        step(2);
    endtask

    task automatic cmd_off();
        ifc.ctrl_in = '0;
        step(2);
    endtask

    task automatic pkts(input int n);
        for (int i = 0; i < n; i++) begin
            ifc.pkt_done = 1'b1;
            step(1);
        end
        ifc.pkt_done = 1'b0;
    endtask

    task automatic sync_pulse();
        ifc.sync_in = 1'b1;
        step(1);
        ifc.sync_in = 1'b0;
    endtask

    function automatic logic [1:0] st();
        return ifc.status_out[1:0];
    endfunction

    initial begin
        ifc.ctrl_in  = '0;
        ifc.sync_in  = 1'b0;
        ifc.pkt_done = 1'b0;
        ifc.tst_load = 1'b0;
        ifc.tst_mcnt = '0;
        step(3);
        chk("rst_tx", 64'(ifc.tx_en), 64'd0);
        chk("rst_mcnt", 64'(ifc.mcnt_o), 64'd0);
        chk("rst_lsb", 64'(ifc.mcnt_lsb_out), 64'd0);
        chk("rst_msb", 64'(ifc.mcnt_msb_out), 64'd0);
        chk("rst_status", 64'(ifc.status_out), 64'd0);
        rst_n = 1'b1;
        step(3);

        // arm, then start with pkt_done coincident with sync
        cmd_on(ARM);
        chk("armed_state", 64'(st()), 64'd1);
        cmd_off();
        pkts(2);
        chk("armed_no_count", 64'(ifc.mcnt_o), 64'd0);
        step(3);
        ifc.pkt_done = 1'b1;
        sync_pulse();
        ifc.pkt_done = 1'b0;
        chk("start_state", 64'(st()), 64'd2);
        chk("start_tx", 64'(ifc.tx_en), 64'd1);
        chk("start_mcnt", 64'(ifc.mcnt_o), 64'd0);
        pkts(7);
        chk("run_mcnt7", 64'(ifc.mcnt_o), 64'd7);

        // snap coincident with a packet at mcnt=7
        ifc.ctrl_in = SNAP;
        step(1);
        ifc.pkt_done = 1'b1;
        step(1);
        ifc.pkt_done = 1'b0;
        chk("snap7_lsb", 64'(ifc.mcnt_lsb_out), 64'd7);
        chk("snap7_mcnt", 64'(ifc.mcnt_o), 64'd8);
        chk("snap7_seq", 64'(ifc.status_out[15:8]), 64'd1);
        cmd_off();
        pkts(2);
        chk("run_mcnt10", 64'(ifc.mcnt_o), 64'd10);

        // clear outside IDLE only flags an error; arm in RUN is ignored
        cmd_on(CLR);
        chk("clr_run_err", 64'(ifc.status_out[4]), 64'd1);
        chk("clr_run_mcnt", 64'(ifc.mcnt_o), 64'd10);
        cmd_off();
        cmd_on(ARM);
        chk("arm_in_run", 64'(st()), 64'd2);
        cmd_off();

        // stop: transmit continues until the next sync
        cmd_on(STOP);
        chk("stopping_state", 64'(st()), 64'd3);
        cmd_off();
        pkts(3);
        chk("stopping_mcnt", 64'(ifc.mcnt_o), 64'd13);
        chk("stopping_tx", 64'(ifc.tx_en), 64'd1);
        ifc.ctrl_in = SNAP;
        step(1);
        ifc.sync_in  = 1'b1;
        ifc.pkt_done = 1'b1;
        step(1);
        ifc.sync_in  = 1'b0;
        ifc.pkt_done = 1'b0;
        chk("stop_state", 64'(st()), 64'd0);
        chk("stop_tx", 64'(ifc.tx_en), 64'd0);
        chk("stop_lsb", 64'(ifc.mcnt_lsb_out), 64'd13);
        chk("stop_msb", 64'(ifc.mcnt_msb_out), 64'd0);
        chk("stop_seq_once", 64'(ifc.status_out[15:8]), 64'd2);
        chk("stop_mcnt", 64'(ifc.mcnt_o), 64'd14);
        cmd_off();
        pkts(3);
        chk("idle_no_count", 64'(ifc.mcnt_o), 64'd14);

        cmd_on(CLR);
        chk("clr_mcnt", 64'(ifc.mcnt_o), 64'd0);
        chk("clr_lsb", 64'(ifc.mcnt_lsb_out), 64'd0);
        chk("clr_msb", 64'(ifc.mcnt_msb_out), 64'd0);
        chk("clr_status", 64'(ifc.status_out), 64'd0);
        cmd_off();

        cmd_on(ARM | STOP);
        chk("arm_stop_idle", 64'(st()), 64'd0);
        cmd_off();
        cmd_on(ARM);
        cmd_off();
        cmd_on(STOP);
        chk("armed_stop", 64'(st()), 64'd0);
        cmd_off();

        // wrap from a preloaded count near the top
        cmd_on(ARM);
        cmd_off();
        sync_pulse();
        chk("wrap_run", 64'(st()), 64'd2);
        ifc.tst_load = 1'b1;
        ifc.tst_mcnt = 48'hFFFF_FFFF_FFFE;
        step(1);
        ifc.tst_load = 1'b0;
        chk("preload", 64'(ifc.mcnt_o), 64'h0000_FFFF_FFFF_FFFE);
        cmd_on(SNAP);
        chk("hi_lsb", 64'(ifc.mcnt_lsb_out), 64'hFFFF_FFFE);
        chk("hi_msb", 64'(ifc.mcnt_msb_out), 64'h0000_FFFF);
        chk("hi_seq", 64'(ifc.status_out[15:8]), 64'd1);
        cmd_off();
        pkts(1);
        chk("top_no_wrap", 64'(ifc.status_out[2]), 64'd0);
        pkts(2);
        chk("wrap_mcnt", 64'(ifc.mcnt_o), 64'd1);
        chk("wrap_bit", 64'(ifc.status_out[2]), 64'd1);
        cmd_on(SNAP);
        chk("wrap_lsb", 64'(ifc.mcnt_lsb_out), 64'd1);
        chk("wrap_msb", 64'(ifc.mcnt_msb_out), 64'd0);
        chk("wrap_status", 64'(ifc.status_out), 64'h20E);
        cmd_off();

        // asynchronous reset mid-RUN with arm held high
        ifc.ctrl_in = ARM;
        step(1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_tx", 64'(ifc.tx_en), 64'd0);
        chk("rst_async_state", 64'(st()), 64'd0);
        chk("rst_async_mcnt", 64'(ifc.mcnt_o), 64'd0);
        step(1);
        rst_n = 1'b1;
        step(4);
        chk("no_rearm_held", 64'(st()), 64'd0);
        cmd_off();
        cmd_on(ARM);
        chk("rearm_toggle", 64'(st()), 64'd1);
        cmd_off();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule

// File: doc/gpu_mcnt_ctrl.md
# gpu_mcnt_ctrl

Controller that sequences the GPU-packet master counter (mcnt) for the F-engine output path: arms on a software command, starts transmission on the next spectrum sync, counts packets, and stops cleanly on a sync boundary. It publishes coherent 32-bit lsb/msb snapshots and a status word. These outputs drive the `user_data_in` ports of the simulink2ppc software registers, so the PPC reads a consistent 64-bit mcnt. Software commands arrive from a ppc2simulink control register.

## Interface
- MCNT_W, 48: mcnt width in bits; legal range 33..64.
- user_clk  in  1  fabric clock; all logic on rising edge.
- user_rst_n  in  1  reset, asynchronous assert, active-low.
- ctrl_in  in  32  software control word, level-written. Bit0 arm, bit1 stop, bit2 snap, bit3 clr; other bits ignored.
- sync_in  in  1  one-cycle spectrum-boundary pulse.
- pkt_done  in  1  one-cycle pulse per GPU packet emitted.
- tx_en  out  1  packetizer transmit enable.
- mcnt_o  out  MCNT_W  live counter value.
- mcnt_lsb_out  out  32  snapshot bits [31:0].
- mcnt_msb_out  out  32  snapshot bits [MCNT_W-1:32], zero-extended.
- status_out  out  32  fields:
  - [1:0] state
  - [2] wrap sticky
  - [3] tx_en
  - [4] clr_err sticky
  - [15:8] snapshot sequence count
  - others 0

## Operation
- **Command capture.** ctrl_in bits [3:0] pass through two registers, ctrl_d then ctrl_q. A command fires on rise = ctrl_d & ~ctrl_q. Software must toggle a bit 0→1 to issue a command again.
- **State machine** (encodings IDLE=0, ARMED=1, RUN=2, STOPPING=3):
  - IDLE, arm rise → ARMED.
  - ARMED, sync_in → RUN. On the same edge: mcnt←0 and tx_en←1.
  - ARMED, stop rise → IDLE.
  - RUN, stop rise → STOPPING.
  - STOPPING, sync_in → IDLE. On the same edge: tx_en←0 and an automatic snapshot of the final mcnt.
  - arm rise in any state other than IDLE is ignored.
- **Simultaneous arm and stop rises:** stop wins. From IDLE, the state stays IDLE.
- **Counting.** In RUN and STOPPING, pkt_done increments mcnt. mcnt wraps from 2^MCNT_W−1 to 0 and sets the wrap sticky bit. pkt_done is ignored in IDLE and ARMED.
- **ARMED with sync_in and pkt_done in the same cycle:** mcnt←0 and the pulse is not counted.
- **Snapshot.** A snap rise, or the automatic snapshot, copies the registered mcnt (pre-increment value) into the lsb/msb outputs on one edge. The 8-bit sequence count increments and wraps 255→0. The outputs hold between snapshots.
- **Snapshot and automatic snapshot on the same edge:** counts as one snapshot; the sequence count increments once.
- **Clear.** clr rise in IDLE zeroes mcnt, the snapshot registers, the sequence count, the wrap sticky bit and the clr_err sticky bit. clr rise in any other state is ignored and sets the clr_err sticky bit.

## Timing
- Reset values:
  - state IDLE
  - tx_en 0
  - mcnt_o 0
  - mcnt_lsb_out 0, mcnt_msb_out 0
  - status_out 0
  - ctrl_d and ctrl_q 0
- **Command latency:** if ctrl_in is sampled high at edge E0, the rise is valid after E0 and its effect registers at E1.
- **sync_in effect:** registers at the same edge that samples the pulse. tx_en and state_out change together.
- **pkt_done to mcnt_o:** 1 cycle.
- **Snapshot:** lsb, msb and sequence count update on one edge, so software reads of the lsb register always pair with the matching msb.
- **Reset mid-operation:** tx_en drops asynchronously. Pending commands are discarded, and the captured ctrl_in history is lost. A level still high after release does not re-fire until it is toggled.

## Structure
- Package gpu_mcnt_pkg holds:
  - state enum
  - ctrl bit indices: ARM=0, STOP=1, SNAP=2, CLR=3
  - status field positions and widths
- Sub-module sw_cmd_edge: 4-bit two-register capture plus rise detect, reused for other software control registers.
- The top level contains the FSM, counter, snapshot registers and status packing.

## Test plan
- **Start:** reset, set arm; sync_in 5 cycles later; 10 pkt_done pulses → state RUN on the sync edge, tx_en=1, mcnt_o=10.
- **Stop:** stop rise in RUN, 3 pkt_done, then sync → tx_en stays 1 until sync. Final mcnt=13 in lsb, msb=0, sequence count=1, state IDLE.
- **Wrap:** preload via test force of mcnt to 2^48−2, then 3 pkt_done → mcnt=1, wrap bit=1. Snapshot gives lsb=1, msb=0.
- **Simultaneous events:**
  - arm and stop rise together in IDLE → state stays IDLE.
  - In ARMED, sync_in with pkt_done → mcnt=0.
  - In RUN, snap with pkt_done at mcnt=7 → lsb=7, mcnt_o=8.
- **Clear:** clr rise in RUN → clr_err=1 and mcnt unaffected. After stop and sync, clr → all counters and stickies 0.
- **Reset:** assert user_rst_n low mid-RUN with ctrl_in arm held high → immediate tx_en=0 and state IDLE. After release, no re-arm until arm is toggled.
